sysid_check_ctrl: RTL and testbench

- Avalon-MM read sequencer for the QSYS system-ID slave (1-bit word address, 32-bit readdata).
- On a start pulse, reads word 0 (ID) then word 1 (timestamp) and compares each against an expected constant.
- Reports pass/fail/timeout to the boot/status logic, so a mismatched FPGA image is flagged before software runs.

---
 rtl/sysid_check_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sysid_check_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: reads the QSYS system-ID slave (ID, then timestamp) and flags image mismatches.
// Optional macro SYSID_RETRY_EN re-runs mismatched sequences up to MAX_RETRY times.
module sysid_check_ctrl #(
    parameter logic [31:0] EXP_ID         = 32'd0,
    parameter logic [31:0] EXP_TS         = 32'd1637860799,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [3:0]  retries,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

`ifdef SYSID_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam logic [15:0] STALL_MAX   = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] STALL_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LAST    = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        CHECK,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] stall_cnt;
    logic [1:0]  lat_cnt;
    logic        accept;
    logic        stall_limit;
    logic        lat_last;
    logic        pass;
    logic        capture_id;
    logic        capture_ts;
    logic        set_timeout;
    logic        do_retry;

    assign avm_read    = (state == RD_ID) || (state == RD_TS);
    assign avm_address = (state == RD_TS);
    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);

    assign accept      = avm_read && !avm_waitrequest;
    // Limit is hit on the TIMEOUT_CYCLES-th stalled cycle; a same-cycle accept takes priority.
    assign stall_limit = avm_read && avm_waitrequest && (stall_cnt == STALL_LAST);
    assign lat_last    = (lat_cnt == LAT_LAST);
    assign pass        = (id_value == EXP_ID) && (ts_value == EXP_TS);

    always_comb begin
        state_nxt   = state;
        capture_id  = 1'b0;
        capture_ts  = 1'b0;
        set_timeout = 1'b0;
        do_retry    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RD_ID;
            end
            RD_ID: begin
                if (accept) begin
                    if (READ_LATENCY == 0) begin
                        capture_id = 1'b1;
                        state_nxt  = RD_TS;
                    end else begin
                        state_nxt  = LAT_ID;
                    end
                end else if (stall_limit) begin
                    set_timeout = 1'b1;
                    state_nxt   = DONE;
                end
            end
            LAT_ID: begin
                if (lat_last) begin
                    capture_id = 1'b1;
                    state_nxt  = RD_TS;
                end
            end
            RD_TS: begin
                if (accept) begin
                    if (READ_LATENCY == 0) begin
                        capture_ts = 1'b1;
                        state_nxt  = CHECK;
                    end else begin
                        state_nxt  = LAT_TS;
                    end
                end else if (stall_limit) begin
                    set_timeout = 1'b1;
                    state_nxt   = DONE;
                end
            end
            LAT_TS: begin
                if (lat_last) begin
                    capture_ts = 1'b1;
                    state_nxt  = CHECK;
                end
            end
            CHECK: begin
                do_retry  = RETRY_EN && !pass && (retries < RETRY_LIMIT);
                state_nxt = do_retry ? RD_ID : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counts stalled cycles of the current read; any accept or idle read strobe restarts it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (!avm_read || accept) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt <= '0;
        end else if (((state == LAT_ID) || (state == LAT_TS)) && !lat_last) begin
            lat_cnt <= lat_cnt + 2'd1;
        end else begin
            lat_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            retries  <= '0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                id_ok    <= 1'b0;
                ts_ok    <= 1'b0;
                timeout  <= 1'b0;
                retries  <= '0;
                id_value <= '0;
                ts_value <= '0;
            end
            if (capture_id) id_value <= avm_readdata;
            if (capture_ts) ts_value <= avm_readdata;
            if (set_timeout) begin
                timeout <= 1'b1;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
            end
            if (state == CHECK) begin
                id_ok <= (id_value == EXP_ID);
                ts_ok <= (ts_value == EXP_TS);
                if (do_retry) retries <= retries + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl: one zero-latency instance, one two-cycle-latency instance with stalls.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_TS0 = 32'd1637860799;
    localparam logic [31:0] ID1     = 32'hCAFE0001;
    localparam logic [31:0] TS1     = 32'h5EED0002;
    localparam logic [31:0] GARB    = 32'hDEADBEEF;
`ifdef SYSID_RETRY_EN
    localparam int MIS_RETRIES = 3;
    localparam int MIS_DONE_AT = 13;
`else
    localparam int MIS_RETRIES = 0;
    localparam int MIS_DONE_AT = 4;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    int          tests = 0;
    int          fails = 0;

    // instance 0: zero latency, bench-driven waitrequest
    logic        start0 = 1'b0;
    logic        busy0, done0, id_ok0, ts_ok0, timeout0, avm_address0, avm_read0;
    logic [3:0]  retries0;
    logic [31:0] id_value0, ts_value0, avm_readdata0;
    logic        avm_waitrequest0 = 1'b0;
    logic [31:0] id_word0 = 32'd0;
    logic [31:0] ts_word0 = EXP_TS0;

    // instance 1: latency 2, slave stalls 3 cycles per read
    logic        start1 = 1'b0;
    logic        busy1, done1, id_ok1, ts_ok1, timeout1, avm_address1, avm_read1;
    logic [3:0]  retries1;
    logic [31:0] id_value1, ts_value1, avm_readdata1;
    logic        avm_waitrequest1;
    logic [3:0]  st_cnt1;
    logic [31:0] pipe1a, pipe1b;

    always #5 clock = ~clock;

    assign avm_readdata0 = avm_address0 ? ts_word0 : id_word0;

    assign avm_waitrequest1 = avm_read1 && (st_cnt1 < 4'd3);
    assign avm_readdata1    = pipe1b;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_cnt1 <= '0;
            pipe1a  <= GARB;
            pipe1b  <= GARB;
        end else begin
            st_cnt1 <= (avm_read1 && avm_waitrequest1) ? st_cnt1 + 4'd1 : 4'd0;
            pipe1a  <= (avm_read1 && !avm_waitrequest1) ? (avm_address1 ? TS1 : ID1) : GARB;
            pipe1b  <= pipe1a;
        end
    end

    sysid_check_ctrl #(
        .READ_LATENCY   (0),
        .TIMEOUT_CYCLES (4)
    ) dut0 (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start0),
        .busy            (busy0),
        .done            (done0),
        .id_ok           (id_ok0),
        .ts_ok           (ts_ok0),
        .timeout         (timeout0),
        .retries         (retries0),
        .id_value        (id_value0),
        .ts_value        (ts_value0),
        .avm_address     (avm_address0),
        .avm_read        (avm_read0),
        .avm_waitrequest (avm_waitrequest0),
        .avm_readdata    (avm_readdata0)
    );

    sysid_check_ctrl #(
        .EXP_ID         (ID1),
        .EXP_TS         (TS1),
        .READ_LATENCY   (2),
        .TIMEOUT_CYCLES (4)
    ) dut1 (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start1),
        .busy            (busy1),
        .done            (done1),
        .id_ok           (id_ok1),
        .ts_ok           (ts_ok1),
        .timeout         (timeout1),
        .retries         (retries1),
        .id_value        (id_value1),
        .ts_value        (ts_value1),
        .avm_address     (avm_address1),
        .avm_read        (avm_read1),
        .avm_waitrequest (avm_waitrequest1),
        .avm_readdata    (avm_readdata1)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [74:0] v0, v1;
        #2;
        v0 = {busy0, done0, id_ok0, ts_ok0, timeout0, retries0, id_value0, ts_value0, avm_read0, avm_address0};
        v1 = {busy1, done1, id_ok1, ts_ok1, timeout1, retries1, id_value1, ts_value1, avm_read1, avm_address1};
        tests++;
        if (v0 !== '0) begin fails++; $display("FAIL reset_outputs0 got %h want 0", v0); end
        tests++;
        if (v1 !== '0) begin fails++; $display("FAIL reset_outputs1 got %h want 0", v1); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [3:0] ctl;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        ctl = {avm_read0, avm_address0, busy0, done0};
        tests++;
        if (ctl !== 4'b1010) begin fails++; $display("FAIL basic_rd_id got %b want 1010", ctl); end
        step();
        ctl = {avm_read0, avm_address0, busy0, done0};
        tests++;
        if (ctl !== 4'b1110) begin fails++; $display("FAIL basic_rd_ts got %b want 1110", ctl); end
        step();
        ctl = {avm_read0, avm_address0, busy0, done0};
        tests++;
        if (ctl !== 4'b0010) begin fails++; $display("FAIL basic_check got %b want 0010", ctl); end
        step();
        ctl = {avm_read0, avm_address0, busy0, done0};
        tests++;
        if (ctl !== 4'b0001) begin fails++; $display("FAIL basic_done got %b want 0001", ctl); end
        tests++;
        if ({id_ok0, ts_ok0, timeout0} !== 3'b110)
            begin fails++; $display("FAIL basic_flags got %b want 110", {id_ok0, ts_ok0, timeout0}); end
        tests++;
        if (ts_value0 !== EXP_TS0)
            begin fails++; $display("FAIL basic_ts_value got %h want %h", ts_value0, EXP_TS0); end
        step();
        tests++;
        if (done0 !== 1'b0) begin fails++; $display("FAIL basic_done_width got %b want 0", done0); end
    endtask

    task automatic test_mismatch();
        int done_at = -1;
        ts_word0 = 32'h12345678;
        start0 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            start0 = 1'b0;
            if (done0 && done_at < 0) done_at = c;
        end
        tests++;
        if (done_at != MIS_DONE_AT)
            begin fails++; $display("FAIL mismatch_done_at got %0d want %0d", done_at, MIS_DONE_AT); end
        tests++;
        if ({id_ok0, ts_ok0, timeout0} !== 3'b100)
            begin fails++; $display("FAIL mismatch_flags got %b want 100", {id_ok0, ts_ok0, timeout0}); end
        tests++;
        if (ts_value0 !== 32'h12345678)
            begin fails++; $display("FAIL mismatch_ts_value got %h want 12345678", ts_value0); end
        tests++;
        if (retries0 !== 4'(MIS_RETRIES))
            begin fails++; $display("FAIL mismatch_retries got %0d want %0d", retries0, MIS_RETRIES); end
        ts_word0 = EXP_TS0;
    endtask

    task automatic test_timeout();
        int reads = 0;
        int done_at = -1;
        bit addr_bad = 1'b0;
        avm_waitrequest0 = 1'b1;
        start0 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            start0 = 1'b0;
            if (avm_read0) begin
                reads++;
                if (avm_address0) addr_bad = 1'b1;
            end
            if (done0 && done_at < 0) done_at = c;
        end
        tests++;
        if (reads != 4) begin fails++; $display("FAIL timeout_read_cycles got %0d want 4", reads); end
        tests++;
        if (addr_bad) begin fails++; $display("FAIL timeout_address got 1 want 0"); end
        tests++;
        if (done_at != 5) begin fails++; $display("FAIL timeout_done_at got %0d want 5", done_at); end
        tests++;
        if ({id_ok0, ts_ok0, timeout0} !== 3'b001)
            begin fails++; $display("FAIL timeout_flags got %b want 001", {id_ok0, ts_ok0, timeout0}); end
        avm_waitrequest0 = 1'b0;
    endtask

    task automatic test_latency_stall();
        int reads = 0;
        int done_at = -1;
        start1 = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            step();
            start1 = 1'b0;
            if (avm_read1) reads++;
            if (done1 && done_at < 0) done_at = c;
        end
        tests++;
        if (done_at != 14) begin fails++; $display("FAIL lat_done_at got %0d want 14", done_at); end
        tests++;
        if (reads != 8) begin fails++; $display("FAIL lat_read_cycles got %0d want 8", reads); end
        tests++;
        if (id_value1 !== ID1) begin fails++; $display("FAIL lat_id_value got %h want %h", id_value1, ID1); end
        tests++;
        if (ts_value1 !== TS1) begin fails++; $display("FAIL lat_ts_value got %h want %h", ts_value1, TS1); end
        tests++;
        if ({id_ok1, ts_ok1, timeout1} !== 3'b110)
            begin fails++; $display("FAIL lat_flags got %b want 110", {id_ok1, ts_ok1, timeout1}); end
    endtask

    task automatic test_reset_mid();
        logic [74:0] v0;
        int dones = 0;
        int done_at = -1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        tests++;
        if ({avm_read0, avm_address0} !== 2'b11)
            begin fails++; $display("FAIL midrst_in_rd_ts got %b want 11", {avm_read0, avm_address0}); end
        #2;
        reset_n = 1'b0;
        #1;
        v0 = {busy0, done0, id_ok0, ts_ok0, timeout0, retries0, id_value0, ts_value0, avm_read0, avm_address0};
        tests++;
        if (v0 !== '0) begin fails++; $display("FAIL midrst_outputs got %h want 0", v0); end
        for (int c = 0; c < 3; c++) begin
            step();
            if (done0) dones++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done0) dones++;
        end
        tests++;
        if (dones != 0) begin fails++; $display("FAIL midrst_no_done got %0d want 0", dones); end
        start0 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            start0 = 1'b0;
            if (done0 && done_at < 0) done_at = c;
        end
        tests++;
        if (done_at != 4) begin fails++; $display("FAIL midrst_rerun_done_at got %0d want 4", done_at); end
        tests++;
        if ({id_ok0, ts_ok0, timeout0} !== 3'b110)
            begin fails++; $display("FAIL midrst_rerun_flags got %b want 110", {id_ok0, ts_ok0, timeout0}); end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        int first_at = -1;
        int second_at = -1;
        logic busy_c5 = 1'b1;
        start0 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (done0) begin
                dones++;
                if (first_at < 0) first_at = c;
                else if (second_at < 0) second_at = c;
            end
            if (c == 5) busy_c5 = busy0;
            start0 = (c == 2) || (c == 4) || (c == 5);
        end
        start0 = 1'b0;
        tests++;
        if (dones != 2) begin fails++; $display("FAIL ignore_done_count got %0d want 2", dones); end
        tests++;
        if (first_at != 4) begin fails++; $display("FAIL ignore_first_done got %0d want 4", first_at); end
        tests++;
        if (busy_c5 !== 1'b0) begin fails++; $display("FAIL ignore_start_in_done got busy %b want 0", busy_c5); end
        tests++;
        if (second_at != 9) begin fails++; $display("FAIL ignore_second_done got %0d want 9", second_at); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_timeout();
        test_latency_stall();
        test_reset_mid();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
